// File: rtl/vic_param.sv
// Vectored interrupt controller: edge/level maskable requests, fixed or
// rotating priority, single-level intr/inta/eoi handshake with the core.
module vic_param #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W = 8,
    parameter logic [VEC_W-1:0] VEC_BASE = 'h20,
    parameter int VEC_SHIFT = 2,
    localparam int ID_W = $clog2(NUM_IRQ + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] edge_mode,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               rotate,
    input  logic               inta,
    input  logic               eoi,
    output logic               intr,
    output logic [VEC_W-1:0]   vector,
    output logic               vector_valid,
    output logic [ID_W-1:0]    active_id,
    output logic [NUM_IRQ-1:0] in_service,
    output logic [NUM_IRQ-1:0] pending
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    localparam logic [ID_W-1:0] NONE = ID_W'(NUM_IRQ);

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] irq_d_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] isv_q, isv_d;
    logic [ID_W-1:0]    aid_q, aid_d;
    logic [ID_W-1:0]    rot_q, rot_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               intr_q, intr_d;
    logic               vv_q, vv_d;

    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [ID_W-1:0]    start, win, win_hi, win_lo;
    logic               hit_hi, hit_lo;

    function automatic logic [VEC_W-1:0] vec_of(input logic [ID_W-1:0] id);
        return VEC_BASE + (VEC_W'(id) << VEC_SHIFT);
    endfunction

    assign cand  = pending_q & ~mask;
    assign start = rotate ? rot_q : '0;

    // First candidate at or above start, else the lowest one (wrap-around).
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        win_hi = NONE;
        win_lo = NONE;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (!hit_hi && cand[i] && ID_W'(i) >= start) begin
                hit_hi = 1'b1;
                win_hi = ID_W'(i);
            end
            if (!hit_lo && cand[i]) begin
                hit_lo = 1'b1;
                win_lo = ID_W'(i);
            end
        end
        win = hit_hi ? win_hi : (hit_lo ? win_lo : NONE);
    end

    always_comb begin
        state_d = state_q;
        intr_d  = intr_q;
        vv_d    = 1'b0;
        vec_d   = vec_q;
        aid_d   = aid_q;
        isv_d   = isv_q;
        rot_d   = rot_q;
        ack_clr = '0;
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = REQ;
                    intr_d  = 1'b1;
                end
            end
            REQ: begin
                if (inta) begin
                    intr_d = 1'b0;
                    vv_d   = 1'b1;
                    if (|cand) begin
                        isv_d   = NUM_IRQ'(1) << win;
                        aid_d   = win;
                        vec_d   = vec_of(win);
                        ack_clr = (NUM_IRQ'(1) << win) & edge_mode;
                        state_d = SERVICE;
                    end else begin
                        aid_d   = NONE;
                        vec_d   = vec_of(NONE);
                        state_d = IDLE;
                    end
                end
            end
            SERVICE: begin
                if (eoi) begin
                    isv_d   = '0;
                    aid_d   = NONE;
                    state_d = IDLE;
                    if (rotate) begin
                        rot_d = (aid_q == ID_W'(NUM_IRQ - 1)) ? '0 : aid_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A fresh edge wins over the acknowledge clear in the same cycle.
    assign pending_d = (edge_mode & ((pending_q & ~ack_clr) | (irq_in & ~irq_d_q)))
                     | (~edge_mode & irq_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            irq_d_q   <= '0;
            pending_q <= '0;
            isv_q     <= '0;
            aid_q     <= NONE;
            rot_q     <= '0;
            vec_q     <= '0;
            intr_q    <= 1'b0;
            vv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            irq_d_q   <= irq_in;
            pending_q <= pending_d;
            isv_q     <= isv_d;
            aid_q     <= aid_d;
            rot_q     <= rot_d;
            vec_q     <= vec_d;
            intr_q    <= intr_d;
            vv_q      <= vv_d;
        end
    end

    assign intr         = intr_q;
    assign vector       = vec_q;
    assign vector_valid = vv_q;
    assign active_id    = aid_q;
    assign in_service   = isv_q;
    assign pending      = pending_q;

endmodule
